// File: rtl/rs_alloc_issue_ctrl.sv
// Reservation-station control: in-order dispatch allocation, single-branch
// speculation tracking, and per-FU round-robin issue selection.
module rs_alloc_issue_ctrl #(
  parameter int unsigned RS_DEPTH       = 16,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned FU_NUM         = 4,
  localparam int unsigned SLOT_W = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1,
  localparam int unsigned FU_W   = (FU_NUM > 1) ? $clog2(FU_NUM) : 1,
  localparam int unsigned IDX_W  = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(RS_DEPTH) + 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [DISPATCH_WIDTH-1:0]         disp_req_i,
  input  logic [DISPATCH_WIDTH-1:0]         disp_is_br_i,
  output logic [DISPATCH_WIDTH-1:0]         disp_grant_o,
  output logic [RS_DEPTH-1:0]               disp_enable_o,
  output logic [RS_DEPTH-1:0][SLOT_W-1:0]   disp_slot_sel_o,
  output logic [RS_DEPTH-1:0]               br_tag_o,
  input  logic [RS_DEPTH-1:0]               entry_empty_i,
  input  logic [RS_DEPTH-1:0]               entry_ready_i,
  input  logic [RS_DEPTH-1:0][FU_W-1:0]     entry_fu_type_i,
  input  logic [FU_NUM-1:0]                 fu_avail_i,
  output logic [RS_DEPTH-1:0]               issue_o,
  output logic [FU_NUM-1:0]                 issue_valid_o,
  output logic [FU_NUM-1:0][IDX_W-1:0]      issue_idx_o,
  input  logic                              br_resolve_i,
  input  logic                              br_mispredict_i,
  output logic                              clear_br_tag_o,
  output logic                              clear_wrong_instr_o,
  output logic [CNT_W-1:0]                  free_count_o
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SPEC    = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  state_e                         state_q, state_d;
  logic [FU_NUM-1:0][IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [RS_DEPTH-1:0]            tag_q, tag_d;

  logic [CNT_W-1:0]               free_cnt;
  logic [DISPATCH_WIDTH-1:0]      grant;
  logic [DISPATCH_WIDTH-1:0]      slot_tag;
  logic                           br_granted;
  logic                           squash;

  // Number of empty entries available for allocation
  always_comb begin
    free_cnt = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      free_cnt = free_cnt + CNT_W'(entry_empty_i[i]);
    end
  end

  assign free_count_o = free_cnt;

  // In-order slot grant: the first refused request blocks all younger slots
  always_comb begin
    logic             blocked;
    logic [CNT_W-1:0] n_grant;
    grant      = '0;
    slot_tag   = '0;
    br_granted = 1'b0;
    blocked    = 1'b0;
    n_grant    = '0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      if (disp_req_i[k] && !blocked) begin
        if (!reset && (state_q != ST_RECOVER) && (n_grant < free_cnt) &&
            !(disp_is_br_i[k] && ((state_q == ST_SPEC) || br_granted))) begin
          grant[k]    = 1'b1;
          slot_tag[k] = (state_q == ST_SPEC) || br_granted;
          n_grant     = n_grant + CNT_W'(1);
          if (disp_is_br_i[k]) begin
            br_granted = 1'b1;
          end
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  assign disp_grant_o = grant;

  // Map the n-th granted slot onto the n-th lowest empty entry
  always_comb begin
    logic [DISPATCH_WIDTH-1:0] rem;
    logic                      found;
    disp_enable_o   = '0;
    disp_slot_sel_o = '0;
    br_tag_o        = '0;
    rem             = grant;
    found           = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (entry_empty_i[i]) begin
        found = 1'b0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
          if (rem[k] && !found) begin
            found              = 1'b1;
            rem[k]             = 1'b0;
            disp_enable_o[i]   = 1'b1;
            disp_slot_sel_o[i] = SLOT_W'(k);
            br_tag_o[i]        = slot_tag[k];
          end
        end
      end
    end
  end

  // Speculation FSM: next state and resolution broadcasts
  always_comb begin
    state_d             = state_q;
    clear_br_tag_o      = 1'b0;
    clear_wrong_instr_o = 1'b0;
    squash              = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (br_granted) begin
          state_d = ST_SPEC;
        end
      end
      ST_SPEC: begin
        if (br_resolve_i) begin
          if (br_mispredict_i) begin
            state_d = ST_RECOVER;
            squash  = 1'b1;
          end else begin
            state_d        = ST_NORMAL;
            clear_br_tag_o = !reset;
          end
        end
      end
      ST_RECOVER: begin
        state_d             = ST_NORMAL;
        clear_wrong_instr_o = !reset;
        squash              = 1'b1;
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Per-FU round-robin pick starting at rr_ptr, wrong-path entries masked
  always_comb begin
    logic [RS_DEPTH-1:0] cand;
    logic                found;
    int unsigned         j;
    issue_o       = '0;
    issue_valid_o = '0;
    issue_idx_o   = '0;
    rr_ptr_d      = rr_ptr_q;
    cand          = '0;
    found         = 1'b0;
    j             = 0;
    for (int unsigned f = 0; f < FU_NUM; f++) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        cand[i] = entry_ready_i[i] && !entry_empty_i[i] &&
                  (entry_fu_type_i[i] == FU_W'(f)) && !(squash && tag_q[i]);
      end
      found = 1'b0;
      if (fu_avail_i[f] && !reset) begin
        for (int unsigned o = 0; o < RS_DEPTH; o++) begin
          j = 32'(rr_ptr_q[f]) + o;
          if (j >= RS_DEPTH) begin
            j = j - RS_DEPTH;
          end
          if (!found && cand[IDX_W'(j)]) begin
            found              = 1'b1;
            issue_valid_o[f]   = 1'b1;
            issue_idx_o[f]     = IDX_W'(j);
            issue_o[IDX_W'(j)] = 1'b1;
            rr_ptr_d[f]        = (j + 1 == RS_DEPTH) ? '0 : IDX_W'(j + 1);
          end
        end
      end
    end
  end

  // Shadow speculative tags: resolution/recovery clears win over new writes
  always_comb begin
    tag_d = tag_q & ~issue_o;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (disp_enable_o[i]) begin
        tag_d[i] = br_tag_o[i];
      end
    end
    if ((state_q == ST_RECOVER) || clear_br_tag_o) begin
      tag_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      rr_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_rs_alloc_issue_ctrl.sv
// Bench for rs_alloc_issue_ctrl: directed scenarios with literal expectations
// followed by randomized traffic checked against a behavioural model.
module tb_rs_alloc_issue_ctrl;

  localparam int unsigned D = 16;
  localparam int unsigned W = 2;
  localparam int unsigned F = 4;
  localparam int NORMAL  = 0;
  localparam int SPEC    = 1;
  localparam int RECOVER = 2;

  logic               clock;
  logic               reset;
  logic [W-1:0]       disp_req_i, disp_is_br_i, disp_grant_o;
  logic [D-1:0]       disp_enable_o, br_tag_o, entry_empty_i, entry_ready_i, issue_o;
  logic [D-1:0][0:0]  disp_slot_sel_o;
  logic [D-1:0][1:0]  entry_fu_type_i;
  logic [F-1:0]       fu_avail_i, issue_valid_o;
  logic [F-1:0][3:0]  issue_idx_o;
  logic               br_resolve_i, br_mispredict_i, clear_br_tag_o, clear_wrong_instr_o;
  logic [4:0]         free_count_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int m_state, n_state;
  int m_rr[F];
  int n_rr[F];
  bit m_tag[D];
  bit n_tag[D];

  // model expectations for the current cycle
  logic [W-1:0] e_grant;
  logic [D-1:0] e_en, e_tag, e_issue;
  int           e_sel[D];
  logic [F-1:0] e_ivalid;
  int           e_iidx[F];
  logic         e_clr_tag, e_clr_wrong;
  int           e_free;

  rs_alloc_issue_ctrl #(.RS_DEPTH(D), .DISPATCH_WIDTH(W), .FU_NUM(F)) dut (
    .clock              (clock),
    .reset              (reset),
    .disp_req_i         (disp_req_i),
    .disp_is_br_i       (disp_is_br_i),
    .disp_grant_o       (disp_grant_o),
    .disp_enable_o      (disp_enable_o),
    .disp_slot_sel_o    (disp_slot_sel_o),
    .br_tag_o           (br_tag_o),
    .entry_empty_i      (entry_empty_i),
    .entry_ready_i      (entry_ready_i),
    .entry_fu_type_i    (entry_fu_type_i),
    .fu_avail_i         (fu_avail_i),
    .issue_o            (issue_o),
    .issue_valid_o      (issue_valid_o),
    .issue_idx_o        (issue_idx_o),
    .br_resolve_i       (br_resolve_i),
    .br_mispredict_i    (br_mispredict_i),
    .clear_br_tag_o     (clear_br_tag_o),
    .clear_wrong_instr_o(clear_wrong_instr_o),
    .free_count_o       (free_count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = NORMAL;
    for (int f = 0; f < F; f++) m_rr[f] = 0;
    for (int i = 0; i < D; i++) m_tag[i] = 1'b0;
  endtask

  // Expected outputs and next model state from the current inputs
  task automatic model_eval();
    int empties[$];
    int gslots[$];
    bit gtag[$];
    bit br_seen, blocked, squash, found;
    int e;
    e_free = 0;
    for (int i = 0; i < D; i++) begin
      if (entry_empty_i[i]) begin
        e_free++;
        empties.push_back(i);
      end
    end
    e_grant = '0;
    br_seen = 1'b0;
    blocked = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (disp_req_i[k] && !blocked) begin
        if (m_state != RECOVER && gslots.size() < empties.size() &&
            !(disp_is_br_i[k] && (m_state == SPEC || br_seen))) begin
          gslots.push_back(k);
          gtag.push_back(m_state == SPEC || br_seen);
          e_grant[k] = 1'b1;
          if (disp_is_br_i[k]) br_seen = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
    e_en  = '0;
    e_tag = '0;
    for (int i = 0; i < D; i++) e_sel[i] = 0;
    for (int n = 0; n < gslots.size(); n++) begin
      e        = empties[n];
      e_en[e]  = 1'b1;
      e_sel[e] = gslots[n];
      e_tag[e] = gtag[n];
    end
    e_clr_tag   = (m_state == SPEC) && br_resolve_i && !br_mispredict_i;
    e_clr_wrong = (m_state == RECOVER);
    squash      = (m_state == RECOVER) || (m_state == SPEC && br_resolve_i && br_mispredict_i);
    e_issue  = '0;
    e_ivalid = '0;
    for (int f = 0; f < F; f++) begin
      e_iidx[f] = 0;
      n_rr[f]   = m_rr[f];
      found     = 1'b0;
      if (fu_avail_i[f]) begin
        for (int o = 0; o < D; o++) begin
          e = (m_rr[f] + o) % D;
          if (!found && entry_ready_i[e] && !entry_empty_i[e] &&
              int'(entry_fu_type_i[e]) == f && !(squash && m_tag[e])) begin
            found       = 1'b1;
            e_ivalid[f] = 1'b1;
            e_iidx[f]   = e;
            e_issue[e]  = 1'b1;
            n_rr[f]     = (e + 1) % D;
          end
        end
      end
    end
    case (m_state)
      SPEC:    n_state = br_resolve_i ? (br_mispredict_i ? RECOVER : NORMAL) : SPEC;
      RECOVER: n_state = NORMAL;
      default: n_state = br_seen ? SPEC : NORMAL;
    endcase
    for (int i = 0; i < D; i++) begin
      n_tag[i] = e_issue[i] ? 1'b0 : m_tag[i];
      if (e_en[i]) n_tag[i] = e_tag[i];
      if (m_state == RECOVER || e_clr_tag) n_tag[i] = 1'b0;
    end
  endtask

  task automatic model_commit();
    m_state = n_state;
    for (int f = 0; f < F; f++) m_rr[f] = n_rr[f];
    for (int i = 0; i < D; i++) m_tag[i] = n_tag[i];
  endtask

  // Compare every meaningful DUT output against the model
  task automatic check_all();
    chk("free_count", 64'(free_count_o), 64'(e_free));
    chk("disp_grant", 64'(disp_grant_o), 64'(e_grant));
    chk("disp_enable", 64'(disp_enable_o), 64'(e_en));
    chk("br_tag", 64'(br_tag_o & e_en), 64'(e_tag));
    for (int i = 0; i < D; i++)
      if (e_en[i]) chk($sformatf("slot_sel[%0d]", i), 64'(disp_slot_sel_o[i]), 64'(e_sel[i]));
    chk("issue", 64'(issue_o), 64'(e_issue));
    chk("issue_valid", 64'(issue_valid_o), 64'(e_ivalid));
    for (int f = 0; f < F; f++)
      if (e_ivalid[f]) chk($sformatf("issue_idx[%0d]", f), 64'(issue_idx_o[f]), 64'(e_iidx[f]));
    chk("clear_br_tag", 64'(clear_br_tag_o), 64'(e_clr_tag));
    chk("clear_wrong_instr", 64'(clear_wrong_instr_o), 64'(e_clr_wrong));
  endtask

  task automatic settle();
    #1;
    model_eval();
    check_all();
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle();
    disp_req_i      = '0;
    disp_is_br_i    = '0;
    entry_empty_i   = '1;
    entry_ready_i   = '0;
    entry_fu_type_i = '0;
    fu_avail_i      = '0;
    br_resolve_i    = 1'b0;
    br_mispredict_i = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic rand_inputs();
    int mode;
    disp_req_i = W'($urandom);
    for (int k = 0; k < W; k++) disp_is_br_i[k] = ($urandom_range(0, 3) == 0);
    mode = $urandom_range(0, 3);
    case (mode)
      0:       entry_empty_i = '1;
      1:       entry_empty_i = D'($urandom);
      2:       entry_empty_i = D'($urandom) & D'($urandom) & D'($urandom);
      default: entry_empty_i = '0;
    endcase
    entry_ready_i = D'($urandom);
    for (int i = 0; i < D; i++) entry_fu_type_i[i] = 2'($urandom);
    fu_avail_i      = F'($urandom);
    br_resolve_i    = ($urandom_range(0, 3) == 0);
    br_mispredict_i = br_resolve_i && ($urandom_range(0, 1) == 1);
  endtask

  initial begin
    idle();
    model_reset();
    do_reset(2);

    // after reset: idle outputs, resolve ignored in NORMAL
    idle(); br_resolve_i = 1'b1; br_mispredict_i = 1'b1;
    settle();
    chk("rst grant", 64'(disp_grant_o), 64'h0);
    chk("rst issue_valid", 64'(issue_valid_o), 64'h0);
    chk("rst clear_wrong", 64'(clear_wrong_instr_o), 64'h0);
    chk("rst clear_tag", 64'(clear_br_tag_o), 64'h0);
    chk("rst free", 64'(free_count_o), 64'd16);
    tick();

    // all empty, two requests
    idle(); disp_req_i = 2'b11;
    settle();
    chk("all_empty grant", 64'(disp_grant_o), 64'h3);
    chk("all_empty enable", 64'(disp_enable_o), 64'h0003);
    chk("all_empty sel0", 64'(disp_slot_sel_o[0]), 64'h0);
    chk("all_empty sel1", 64'(disp_slot_sel_o[1]), 64'h1);
    tick();

    // only entry 5 empty
    idle(); disp_req_i = 2'b11; entry_empty_i = 16'h0020;
    settle();
    chk("one_empty grant", 64'(disp_grant_o), 64'h1);
    chk("one_empty enable", 64'(disp_enable_o), 64'h0020);
    tick();

    // move rr_ptr[0] to 3, then round-robin between entries 2 and 9
    idle(); entry_empty_i = ~16'h0004; entry_ready_i = 16'h0004; fu_avail_i = 4'b0001;
    settle();
    chk("rr setup idx", 64'(issue_idx_o[0]), 64'd2);
    tick();
    idle(); entry_empty_i = ~16'h0204; entry_ready_i = 16'h0204; fu_avail_i = 4'b0001;
    settle();
    chk("rr first idx", 64'(issue_idx_o[0]), 64'd9);
    chk("rr first issue", 64'(issue_o), 64'h0200);
    tick();
    settle();
    chk("rr wrap idx", 64'(issue_idx_o[0]), 64'd2);
    tick();

    // branch then ALU: tags {0,1}, enter SPEC
    idle(); disp_req_i = 2'b11; disp_is_br_i = 2'b01;
    settle();
    chk("br grant", 64'(disp_grant_o), 64'h3);
    chk("br tags", 64'(br_tag_o), 64'h0002);
    tick();
    idle(); disp_req_i = 2'b01; disp_is_br_i = 2'b01;
    settle();
    chk("spec 2nd branch", 64'(disp_grant_o), 64'h0);
    tick();
    idle(); disp_req_i = 2'b11; disp_is_br_i = 2'b10;
    settle();
    chk("spec alu grant", 64'(disp_grant_o), 64'h1);
    chk("spec alu tag", 64'(br_tag_o), 64'h0001);
    tick();

    // mispredict cycle: tagged entries 0,1 held back, entry 2 issues
    idle();
    entry_empty_i = ~16'h0007; entry_ready_i = 16'h0007;
    entry_fu_type_i[1] = 2'd1; entry_fu_type_i[2] = 2'd2;
    fu_avail_i = 4'b0111; br_resolve_i = 1'b1; br_mispredict_i = 1'b1; disp_req_i = 2'b01;
    settle();
    chk("mis issue", 64'(issue_o), 64'h0004);
    tick();
    // RECOVER cycle
    br_resolve_i = 1'b0; br_mispredict_i = 1'b0; disp_req_i = 2'b11;
    settle();
    chk("rec clear_wrong", 64'(clear_wrong_instr_o), 64'h1);
    chk("rec grant", 64'(disp_grant_o), 64'h0);
    chk("rec issue", 64'(issue_o), 64'h0004);
    tick();
    // back in NORMAL: branch accepted
    idle(); entry_empty_i = ~16'h0003; entry_ready_i = 16'h0003; entry_fu_type_i[1] = 2'd1;
    fu_avail_i = 4'b0011; disp_req_i = 2'b01; disp_is_br_i = 2'b01;
    settle();
    chk("post_rec grant", 64'(disp_grant_o), 64'h1);
    chk("post_rec clear_wrong", 64'(clear_wrong_instr_o), 64'h0);
    tick();

    // correct resolve
    idle(); disp_req_i = 2'b01; br_resolve_i = 1'b1;
    settle();
    chk("ok clear_tag", 64'(clear_br_tag_o), 64'h1);
    tick();
    idle(); disp_req_i = 2'b01; disp_is_br_i = 2'b01; entry_empty_i = ~16'h0001;
    settle();
    chk("ok normal branch", 64'(disp_grant_o), 64'h1);
    chk("ok normal enable", 64'(disp_enable_o), 64'h0002);
    tick();
    // entry 0 tag was cleared by the correct resolve, so it survives a mispredict
    idle(); entry_empty_i = ~16'h0001; entry_ready_i = 16'h0001; fu_avail_i = 4'b0001;
    br_resolve_i = 1'b1; br_mispredict_i = 1'b1;
    settle();
    chk("cleared tag issue", 64'(issue_o), 64'h0001);
    tick();
    idle();
    settle();
    tick();

    // reset in the middle of SPEC with a mispredict pending
    idle(); disp_req_i = 2'b01; disp_is_br_i = 2'b01;
    settle();
    chk("pre_rst branch", 64'(disp_grant_o), 64'h1);
    tick();
    idle(); br_resolve_i = 1'b1; br_mispredict_i = 1'b1;
    do_reset(1);
    disp_req_i = 2'b01; disp_is_br_i = 2'b01;
    entry_empty_i = ~16'h0204; entry_ready_i = 16'h0204; fu_avail_i = 4'b0001;
    settle();
    chk("midrst clear_wrong", 64'(clear_wrong_instr_o), 64'h0);
    chk("midrst branch grant", 64'(disp_grant_o), 64'h1);
    chk("midrst rr idx", 64'(issue_idx_o[0]), 64'd2);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        rand_inputs();
        do_reset(1);
      end
      rand_inputs();
      settle();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_alloc_issue_ctrl.md
RS_ALLOC_ISSUE_CTRL -- requirements
Module: rs_alloc_issue_ctrl

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 16, number of RS entries controlled.
REQ-002 SHALL have parameter DISPATCH_WIDTH, default 2, dispatch slots per cycle.
REQ-003 SHALL have parameter FU_NUM, default 4, FU types; type 3 = FU_BRANCH.
REQ-004 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port disp_req_i, input, DISPATCH_WIDTH, per-slot dispatch request; slot 0 is the oldest.
REQ-007 SHALL have port disp_is_br_i, input, DISPATCH_WIDTH, slot carries a branch.
REQ-008 SHALL have port disp_grant_o, output, DISPATCH_WIDTH, slot accepted this cycle.
REQ-009 SHALL have port disp_enable_o, output, RS_DEPTH, per-entry write enable.
REQ-010 SHALL have port disp_slot_sel_o, output, RS_DEPTH x clog2(DISPATCH_WIDTH), source slot for each enabled entry.
REQ-011 SHALL have port br_tag_o, output, RS_DEPTH, speculative tag written into each enabled entry.
REQ-012 SHALL have port entry_empty_i, input, RS_DEPTH, registered empty flag per entry.
REQ-013 SHALL have port entry_ready_i, input, RS_DEPTH, operands-ready flag per entry.
REQ-014 SHALL have port entry_fu_type_i, input, RS_DEPTH x clog2(FU_NUM), FU type per entry.
REQ-015 SHALL have port fu_avail_i, input, FU_NUM, FU can accept an issue this cycle.
REQ-016 SHALL have port issue_o, output, RS_DEPTH, per-entry issue strobe.
REQ-017 SHALL have ports issue_valid_o, output, FU_NUM, and issue_idx_o, output, FU_NUM x clog2(RS_DEPTH), per-FU grant and entry index.
REQ-018 SHALL have ports br_resolve_i, input, 1, and br_mispredict_i, input, 1, outstanding-branch resolution (mispredict valid only with resolve).
REQ-019 SHALL have ports clear_br_tag_o, output, 1, and clear_wrong_instr_o, output, 1, broadcast to all entries.
REQ-020 SHALL have port free_count_o, output, clog2(RS_DEPTH)+1, popcount(entry_empty_i), combinational.

Function
REQ-021 SHALL keep FSM state: NORMAL, SPEC (one unresolved branch), RECOVER (one-cycle flush).
REQ-022 SHALL grant slot k iff disp_req_i[k], every lower requested slot granted, the granted count is <= empty entries, state is not RECOVER, and the slot is not a branch while SPEC or after an earlier branch granted this cycle.
REQ-023 SHALL map the n-th granted slot to the n-th lowest-index empty entry; entries freed this cycle are not reused until entry_empty_i shows them.
REQ-024 SHALL drive br_tag_o=1 for an enabled entry iff state is SPEC or an older slot granted this cycle is a branch; a branch's own tag is 0.
REQ-025 SHALL transition NORMAL->SPEC when a branch slot is granted.
REQ-026 SHALL in SPEC on br_resolve_i & !br_mispredict_i pulse clear_br_tag_o that cycle and go to NORMAL.
REQ-027 SHALL in SPEC on br_resolve_i & br_mispredict_i go to RECOVER and pulse clear_wrong_instr_o for exactly the RECOVER cycle, then go to NORMAL.
REQ-028 SHALL keep shadow tag vector tag_q[RS_DEPTH]: set from br_tag_o on dispatch, cleared on clear_br_tag_o, issue, or RECOVER.
REQ-029 SHALL per FU f select among entries with ready & !empty & fu_type==f the first at or after rr_ptr[f], wrapping mod RS_DEPTH, only when fu_avail_i[f].
REQ-030 SHALL on grant set rr_ptr[f] <= (idx+1) mod RS_DEPTH; hold otherwise.
REQ-031 SHALL suppress issue of entries with tag_q=1 during the mispredict cycle and the RECOVER cycle.
REQ-032 SHALL set issue_o to the OR of one-hot per-FU grants; issue_o has at most FU_NUM bits set.
REQ-033 SHALL give reset priority over all events, including a mid-SPEC reset.

Reset
REQ-034 SHALL on reset set state NORMAL, rr_ptr all 0, tag_q all 0; all grant/issue/clear outputs 0 in the cycle after reset.

Verification
REQ-035 SHALL pass: all 16 entries empty, disp_req_i=2'b11 -> disp_grant_o=2'b11, disp_enable_o=0x0003, slot_sel entry0=0, entry1=1.
REQ-036 SHALL pass: only entry 5 empty, disp_req_i=2'b11 -> disp_grant_o=2'b01, disp_enable_o=0x0020.
REQ-037 SHALL pass: entries 2,9 ready type 0, rr_ptr[0]=3, fu_avail_i[0]=1 -> issue_idx_o[0]=9, next rr_ptr[0]=10; repeat -> idx 2.
REQ-038 SHALL pass: NORMAL, slots {branch, ALU} granted -> entry tags {0,1}, state SPEC; a further branch request is not granted.
REQ-039 SHALL pass: SPEC, br_resolve_i=1 with br_mispredict_i=1 -> next cycle clear_wrong_instr_o=1, no dispatch grant, tagged ready entries not issued; following cycle NORMAL.
REQ-040 SHALL pass: SPEC, correct resolve -> clear_br_tag_o=1 same cycle, tag_q=0, state NORMAL.
